cons_solve_ctrl: RTL and testbench
==================================

Name: cons_solve_ctrl

Overview:
- Sequencing controller for the combinational constraint-split network (split_* blocks, each producing one constraint bit).
- Generates candidate stimulus words with an LFSR and drives them into the network.
- Waits a programmable settle time, then samples the constraint bits.
- Returns the first candidate that satisfies every enabled constraint, over a valid/ready handshake, with a bounded retry count.

Parameters:
- NUM_CONS, 16: number of constraint result bits collected from split blocks.
- SETTLE_CYC, 1: cycles spent in EVAL for the combinational network to settle (minimum 1).
- TRY_W, 10: width of the try counter; the try limit is 2^TRY_W - 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start_i  in  1  pulse; begins a solve when sampled in IDLE, ignored otherwise.
- abort_i  in  1  forces return to IDLE from any state; has priority over all other events.
- seed_load_i  in  1  loads seed_i into the LFSR when sampled in IDLE.
- seed_i  in  32  LFSR seed; value 0 is replaced by 32'h1.
- cons_en_i  in  NUM_CONS  per-constraint enable mask.
- cons_ok_i  in  NUM_CONS  constraint results from the split network.
- cand_o  out  32  registered candidate word driven to the split network.
- sol_valid_o  out  1  solution available.
- sol_ready_i  in  1  consumer accepts the solution.
- sol_data_o  out  32  satisfying candidate.
- tries_o  out  TRY_W  candidates evaluated in the current or last solve.
- busy_o  out  1  high in every state except IDLE.
- fail_o  out  1  one-cycle pulse when the try limit is exhausted.

Behaviour:
- Reset values: LFSR = 32'h1; state IDLE; cand_o = 0; sol_valid_o = 0; sol_data_o = 0; tries_o = 0; busy_o = 0; fail_o = 0.
- LFSR step (Galois, right shift): next = {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 0). The LFSR advances only on exit from GEN.
- FSM states: IDLE, GEN, EVAL, CHECK, HOLD.
- IDLE:
  - seed_load_i loads the LFSR (0 becomes 1).
  - start_i clears tries_o to 0 and moves to GEN.
  - If seed_load_i and start_i are sampled together, the seed loads first and the solve uses it.
- GEN (1 cycle): cand_o <= LFSR next value; LFSR <= same value; tries_o += 1; go to EVAL.
- EVAL: stays SETTLE_CYC cycles, counted by an internal counter; then goes to CHECK.
- CHECK (1 cycle):
  - pass = &(cons_ok_i | ~cons_en_i). An all-zero mask always passes.
  - pass: sol_data_o <= cand_o; sol_valid_o <= 1; go to HOLD.
  - fail with tries_o == 2^TRY_W - 1: fail_o pulses 1 for the next cycle; go to IDLE.
  - fail otherwise: go to GEN.
- HOLD:
  - sol_valid_o and sol_data_o stay stable until sol_valid_o && sol_ready_i.
  - On that handshake, sol_valid_o clears on the next edge and the state returns to IDLE.
  - sol_ready_i asserted early (before valid) has no effect.
- Latency: sol_valid_o is high 2+SETTLE_CYC edges after the edge that samples start_i (3 at defaults).
- tries_o holds its final value in IDLE until the next start.
- abort_i in any state: next state IDLE; sol_valid_o cleared; fail_o not pulsed; LFSR and cand_o keep their current values.
- Asynchronous reset mid-solve returns every output to its reset value immediately.
- cons_ok_i is sampled only in CHECK; changes in other states are ignored.

Test Plan:
- Reset, seed_load 1, start, cons_en all 1, cons_ok all 1:
  - cand_o = 32'h80200003;
  - sol_valid_o 3 edges after start, sol_data_o = 32'h80200003, tries_o = 1.
- Seed 1; cons_ok = all 1 only while cand_o == 32'hC0300002, else 0:
  - solution 32'hC0300002, tries_o = 2;
  - sol_valid_o 6 edges after start.
- cons_en_i = 0, cons_ok_i = 0:
  - passes on the first candidate, tries_o = 1.
- TRY_W = 3, cons_ok all 0, cons_en all 1:
  - exactly 7 GEN cycles;
  - fail_o pulses for one cycle; busy_o drops; sol_valid_o never asserted.
- HOLD with sol_ready_i low for 5 cycles:
  - sol_data_o stable throughout;
  - ready high for 1 cycle → valid low next cycle, IDLE; start ignored while busy.
- Abort and reset mid-solve:
  - abort_i in EVAL → IDLE next cycle, no fail_o, no sol_valid_o;
  - seed_load 0 → first cand_o = 32'h80200003;
  - async rst_n low mid-EVAL → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/cons_solve_ctrl.sv
// cons_solve_ctrl: sequencing controller for the combinational constraint-split network.
//
// A 32-bit Galois LFSR generates candidate stimulus words. Each candidate is registered
// onto cand_o, allowed SETTLE_CYC cycles to propagate through the split network, and the
// constraint bits are then sampled. The first candidate that satisfies every enabled
// constraint is returned over a valid/ready handshake. The number of tries is bounded by
// 2^TRY_W - 1; exhausting it raises a one-cycle fail_o pulse.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start_i       begin a solve (IDLE only)
//   abort_i       return to IDLE from any state, highest priority
//   seed_load_i   load seed_i into the LFSR (IDLE only); a zero seed becomes 32'h1
//   seed_i        LFSR seed
//   cons_en_i     per-constraint enable mask
//   cons_ok_i     constraint results from the split network
//   cand_o        registered candidate word driven to the split network
//   sol_valid_o   solution available
//   sol_ready_i   consumer accepts the solution
//   sol_data_o    satisfying candidate
//   tries_o       candidates evaluated in the current or last solve
//   busy_o        high in every state except IDLE
//   fail_o        one-cycle pulse when the try limit is exhausted

module cons_solve_ctrl #(
    parameter int unsigned NUM_CONS   = 16,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned TRY_W      = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                seed_load_i,
    input  logic [31:0]         seed_i,
    input  logic [NUM_CONS-1:0] cons_en_i,
    input  logic [NUM_CONS-1:0] cons_ok_i,
    output logic [31:0]         cand_o,
    output logic                sol_valid_o,
    input  logic                sol_ready_i,
    output logic [31:0]         sol_data_o,
    output logic [TRY_W-1:0]    tries_o,
    output logic                busy_o,
    output logic                fail_o
);

    localparam int unsigned   CntW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
    localparam logic [31:0]   LfsrPoly   = 32'h8020_0003;

    typedef enum logic [2:0] {
        StIdle,
        StGen,
        StEval,
        StCheck,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [31:0]       cand_q, cand_d;
    logic              sol_valid_q, sol_valid_d;
    logic [31:0]       sol_data_q, sol_data_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic              fail_q, fail_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [31:0]       lfsr_next;
    logic              cons_pass;

    // Galois right-shift step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LfsrPoly : 32'h0);
    endfunction

    assign lfsr_next = lfsr_step(lfsr_q);
    // Disabled constraints are forced true, so an all-zero mask always passes.
    assign cons_pass = &(cons_ok_i | ~cons_en_i);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cand_d      = cand_q;
        sol_valid_d = sol_valid_q;
        sol_data_d  = sol_data_q;
        tries_d     = tries_q;
        fail_d      = 1'b0;
        cnt_d       = cnt_q;

        if (abort_i) begin
            // LFSR, candidate and try count are deliberately left untouched.
            state_d     = StIdle;
            sol_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Seed is loaded on this edge, so a simultaneous start uses it in GEN.
                    if (seed_load_i) begin
                        lfsr_d = (seed_i == 32'h0) ? 32'h1 : seed_i;
                    end
                    if (start_i) begin
                        tries_d = '0;
                        state_d = StGen;
                    end
                end
                StGen: begin
                    cand_d  = lfsr_next;
                    lfsr_d  = lfsr_next;
                    tries_d = tries_q + 1'b1;
                    cnt_d   = '0;
                    state_d = StEval;
                end
                StEval: begin
                    if (cnt_q == SettleLast) begin
                        state_d = StCheck;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StCheck: begin
                    if (cons_pass) begin
                        sol_data_d  = cand_q;
                        sol_valid_d = 1'b1;
                        state_d     = StHold;
                    end else if (tries_q == '1) begin
                        fail_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StGen;
                    end
                end
                StHold: begin
                    if (sol_valid_q && sol_ready_i) begin
                        sol_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lfsr_q      <= 32'h1;
            cand_q      <= 32'h0;
            sol_valid_q <= 1'b0;
            sol_data_q  <= 32'h0;
            tries_q     <= '0;
            fail_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cand_q      <= cand_d;
            sol_valid_q <= sol_valid_d;
            sol_data_q  <= sol_data_d;
            tries_q     <= tries_d;
            fail_q      <= fail_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cand_o      = cand_q;
    assign sol_valid_o = sol_valid_q;
    assign sol_data_o  = sol_data_q;
    assign tries_o     = tries_q;
    assign busy_o      = (state_q != StIdle);
    assign fail_o      = fail_q;

endmodule

// File: tb/tb_cons_solve_ctrl.sv
// Self-checking bench for cons_solve_ctrl. Expected solutions are queued when a solve is
// started; a monitor pops and compares them on every valid/ready handshake. A second
// instance with TRY_W = 3 exercises try-limit exhaustion.

module tb_cons_solve_ctrl;

    localparam int NC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic          start, abort, seed_load, sol_ready;
    logic [31:0]   seed;
    logic [NC-1:0] cons_en, cons_ok;
    logic [31:0]   cand, sol_data;
    logic          sol_valid, busy, fail;
    logic [9:0]    tries;
    int            mode;

    // 0: all pass, 1: pass only on cand == C0300002, 2: all fail
    always_comb begin
        cons_ok = '0;
        if (mode == 0) cons_ok = '1;
        else if (mode == 1) cons_ok = (cand == 32'hC030_0002) ? '1 : '0;
    end

    cons_solve_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .seed_load_i (seed_load),
        .seed_i      (seed),
        .cons_en_i   (cons_en),
        .cons_ok_i   (cons_ok),
        .cand_o      (cand),
        .sol_valid_o (sol_valid),
        .sol_ready_i (sol_ready),
        .sol_data_o  (sol_data),
        .tries_o     (tries),
        .busy_o      (busy),
        .fail_o      (fail)
    );

    // Small instance for try-limit exhaustion
    logic          t_start, t_abort, t_seed_load, t_ready;
    logic [31:0]   t_seed, t_cand, t_data;
    logic [NC-1:0] t_en, t_ok;
    logic          t_valid, t_busy, t_fail;
    logic [2:0]    t_tries;

    cons_solve_ctrl #(.NUM_CONS(NC), .SETTLE_CYC(1), .TRY_W(3)) dut_t (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (t_start),
        .abort_i     (t_abort),
        .seed_load_i (t_seed_load),
        .seed_i      (t_seed),
        .cons_en_i   (t_en),
        .cons_ok_i   (t_ok),
        .cand_o      (t_cand),
        .sol_valid_o (t_valid),
        .sol_ready_i (t_ready),
        .sol_data_o  (t_data),
        .tries_o     (t_tries),
        .busy_o      (t_busy),
        .fail_o      (t_fail)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [9:0]  tries;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs are driven and outputs checked 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Count edges after the start-sampling edge until sol_valid is seen; -1 on timeout.
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            step();
            n++;
            if (sol_valid) return;
        end
        n = -1;
    endtask

    // Scoreboard monitor: sampled mid-cycle, the handshake takes effect at the next edge.
    always @(negedge clk) begin
        if (rst_n && sol_valid && sol_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got data %h, expected no solution", sol_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_data", sol_data, mon_e.data);
                chk("sb_tries", 32'(tries), 32'(mon_e.tries));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gens;
        logic [31:0] prev;
        logic seen_fail, seen_valid;

        start = 0; abort = 0; seed_load = 0; seed = 0; sol_ready = 0;
        cons_en = '1; mode = 0;
        t_start = 0; t_abort = 0; t_seed_load = 0; t_seed = 0; t_ready = 0;
        t_en = '1; t_ok = '0;

        // Reset state
        step(); step();
        chk("rst_cand", cand, 32'h0);
        chk("rst_valid", 32'(sol_valid), 32'h0);
        chk("rst_data", sol_data, 32'h0);
        chk("rst_tries", 32'(tries), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fail", 32'(fail), 32'h0);
        rst_n = 1'b1;
        step();

        // Seed load together with start, everything passes
        seed = 32'h1; seed_load = 1'b1; start = 1'b1;
        sb_q.push_back('{data: 32'h8020_0003, tries: 10'd1});
        step();
        seed_load = 1'b0; start = 1'b0;
        wait_valid(20, n);
        chk("t1_latency", 32'(n), 32'd3);
        chk("t1_cand", cand, 32'h8020_0003);
        chk("t1_tries", 32'(tries), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);

        // HOLD with ready low; start pulsed mid-hold must be ignored
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            step();
            chk("hold_data", sol_data, 32'h8020_0003);
            chk("hold_valid", 32'(sol_valid), 32'd1);
        end
        start = 1'b0;
        sol_ready = 1'b1;
        step();
        sol_ready = 1'b0;
        chk("t1_valid_clr", 32'(sol_valid), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        step();
        chk("t1_stay_idle", 32'(busy), 32'd0);
        chk("t1_tries_held", 32'(tries), 32'd1);

        // Second candidate passes only
        seed = 32'h1; seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        mode = 1;
        sb_q.push_back('{data: 32'hC030_0002, tries: 10'd2});
        pulse_start();
        wait_valid(40, n);
        chk("t2_latency", 32'(n), 32'd6);
        sol_ready = 1'b1;
        step();
        sol_ready = 1'b0;
        chk("t2_valid_clr", 32'(sol_valid), 32'd0);

        // All-zero mask passes on the first candidate; ready held high early
        cons_en = '0; mode = 2; sol_ready = 1'b1;
        sb_q.push_back('{data: 32'h6018_0001, tries: 10'd1});
        pulse_start();
        wait_valid(20, n);
        chk("t3_latency", 32'(n), 32'd3);
        step();
        chk("t3_valid_clr", 32'(sol_valid), 32'd0);
        sol_ready = 1'b0; cons_en = '1; mode = 0;

        // Zero seed becomes 1; abort in EVAL
        seed = 32'h0; seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        pulse_start();
        step();
        chk("t4_cand", cand, 32'h8020_0003);
        chk("t4_busy_eval", 32'(busy), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_abort_idle", 32'(busy), 32'd0);
        chk("t4_abort_valid", 32'(sol_valid), 32'd0);
        chk("t4_abort_fail", 32'(fail), 32'd0);
        chk("t4_abort_cand", cand, 32'h8020_0003);
        step();
        chk("t4_abort_fail2", 32'(fail), 32'd0);
        chk("t4_abort_valid2", 32'(sol_valid), 32'd0);

        // LFSR retained across abort
        sb_q.push_back('{data: 32'hC030_0002, tries: 10'd1});
        sol_ready = 1'b1;
        pulse_start();
        wait_valid(20, n);
        chk("t4b_latency", 32'(n), 32'd3);
        step();
        sol_ready = 1'b0;

        // Asynchronous reset mid-EVAL
        pulse_start();
        step();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_cand", cand, 32'h0);
        chk("t5_data", sol_data, 32'h0);
        chk("t5_tries", 32'(tries), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_valid", 32'(sol_valid), 32'h0);
        chk("t5_fail", 32'(fail), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Try-limit exhaustion with TRY_W = 3
        prev = t_cand;
        gens = 0; seen_fail = 1'b0; seen_valid = 1'b0;
        t_start = 1'b1;
        step();
        t_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (t_cand != prev) gens++;
            prev = t_cand;
            if (t_valid) seen_valid = 1'b1;
            if (t_fail) begin
                seen_fail = 1'b1;
                chk("t6_busy_at_fail", 32'(t_busy), 32'd0);
                chk("t6_tries", 32'(t_tries), 32'd7);
                break;
            end
        end
        chk("t6_fail_seen", 32'(seen_fail), 32'd1);
        chk("t6_gens", 32'(gens), 32'd7);
        chk("t6_no_valid", 32'(seen_valid), 32'd0);
        step();
        chk("t6_fail_pulse", 32'(t_fail), 32'd0);
        chk("t6_idle", 32'(t_busy), 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
